fb_scan_reader: RTL
===================

# fb_scan_reader

Raster read-back engine for the pixel framebuffer that the coordinate-to-address writer fills. On a START pulse it walks every framebuffer address in order and issues one read per address. It turns each address back into its (Xcoord, Ycoord) pair, using the same mapping the writer uses (Addr = Xcoord*X_RESOL + Ycoord). It delivers each pixel with its coordinates on a valid/ready stream toward display/readout logic.

## Interface
- X_RESOL, 16, stride: number of Ycoord values per Xcoord (Ycoord range 0..X_RESOL-1)
- X_ROWS, 16, number of Xcoord values (Xcoord range 0..X_ROWS-1)
- DATA_W, 8, pixel width
- ADDR_W, 8, framebuffer address width; X_RESOL*X_ROWS <= 2^ADDR_W is required (elaboration error otherwise)
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle pulse; begins a frame scan when idle
- BUSY  out  1  scan in progress
- DONE  out  1  one-cycle pulse after the last pixel handshake
- RdAddr  out  ADDR_W  framebuffer read address
- RdEn  out  1  read strobe; RdData is valid exactly 1 cycle later
- RdData  in  DATA_W  framebuffer read data
- OutData  out  DATA_W  pixel value
- OutX  out  16  Xcoord of pixel
- OutY  out  16  Ycoord of pixel
- OutFirst  out  1  marks pixel (0,0)
- OutLast  out  1  marks pixel (X_ROWS-1, X_RESOL-1)
- OutValid  out  1  stream valid
- OutReady  in  1  stream ready

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: START=1 loads addr=0, x=0, y=0, then goes to SCAN.
  - START while in SCAN or DRAIN is ignored.
- SCAN: issue a read (RdEn=1, RdAddr=addr) in a cycle when fifo_count + inflight <= 2. Both terms are registered, so there is no combinational path from OutReady to RdEn.
  - Each issue advances the counters: y increments; at y==X_RESOL-1, y wraps to 0 and x increments; addr increments.
  - Counters run alongside the address; there is no divider.
  - Issuing the last address (X_ROWS*X_RESOL-1) moves the FSM to DRAIN.
- Read response: data arriving 1 cycle after RdEn is pushed into a 3-entry FIFO together with {x, y, first, last}, which travel in a 1-stage side pipeline.
- DRAIN: no reads are issued. When the FIFO is empty and inflight==0, the FSM pulses DONE for one cycle and returns to IDLE.
- Handshake: a pixel transfers on OutValid & OutReady.
  - OutData/OutX/OutY/OutFirst/OutLast hold stable while OutValid=1 and OutReady=0.
  - OutValid never drops without a handshake.
- Width rules: OutX and OutY are zero-extended from the counters to 16 bits. The addr counter is ADDR_W bits and never wraps within a frame.
- Reset, async and at any time including mid-scan:
  - FSM goes to IDLE; FIFO and in-flight read are flushed.
  - BUSY=0, DONE=0, RdEn=0, RdAddr=0, OutValid=0, OutData=0, OutX=0, OutY=0, OutFirst=0, OutLast=0.
  - Read data returning after reset is discarded.

## Timing
- START sampled at edge 0 -> first RdEn (addr 0) in cycle 1, BUSY=1 from cycle 1.
  - RdData is captured at the end of cycle 2; first OutValid is in cycle 3.
- With OutReady held high: 1 pixel/cycle sustained, no bubbles.
  - For the 16x16 default frame, the last handshake is in cycle 258. DONE=1 and BUSY=0 in cycle 259.
- Backpressure: at most 3 pixels are buffered plus 0 in flight, i.e. the FIFO never overflows.
  - Reads resume the cycle after the occupancy sum falls to <=2.
- START in the same cycle as DONE is ignored. START accepted in cycle 260 starts a new frame.

## Structure
- Package fb_pkg holds:
  - COORD_W=16
  - the default ADDR_W/DATA_W
  - a typedef for the pixel record {data, x, y, first, last}
  - the scan FSM state enum
- Sub-module fb_fifo is a 3-entry synchronous FIFO of pixel records with async active-low reset. It exposes count, push, pop and head outputs. The FSM and counters stay in fb_scan_reader.

## Test plan
- Reset then START, OutReady=1, memory holds data=addr[7:0] -> 256 handshakes with (X,Y,Data) = (addr/16, addr%16, addr). OutFirst only on (0,0), OutLast only on (15,15). DONE in cycle 259.
- Hold OutReady=0 after START -> exactly 3 RdEn pulses (addr 0,1,2), OutValid=1 with stable OutData=0. Raising OutReady resumes in order with no loss or duplication.
- Random OutReady (50%) over a full frame -> pixel sequence identical to the first scenario. No RdEn while fifo_count+inflight==3.
- START pulsed again at cycles 5 and 100 of a scan -> ignored. Single DONE; second frame starts only after a START in IDLE.
- ARESETN low during cycle 50 of a scan -> all outputs 0 the same cycle. After release, no OutValid until a new START, and the next frame starts at (0,0).
- X_RESOL=4, X_ROWS=3 -> 12 pixels with Y wrapping 0..3. OutLast on (2,3). DONE 1 cycle after the 12th handshake.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types for the framebuffer raster read-back path.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package fb_pkg;

  localparam int COORD_W   = 16;
  localparam int FB_ADDR_W = 8;
  localparam int FB_DATA_W = 8;

  // Coordinates and frame markers that ride alongside a read in flight.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               first;
    logic               last;
  } pix_meta_t;

  // One delivered pixel at the default data width.
  typedef struct packed {
    logic [FB_DATA_W-1:0] data;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic                 first;
    logic                 last;
  } pix_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_fifo.sv
// Three-entry synchronous FIFO of pixel records.
// Latency: a push is visible on head/count the cycle after it is written.
// Backpressure: pushes are dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module fb_fifo #(
  parameter type rec_t = fb_pkg::pix_t
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       push,
  input  rec_t       push_rec,
  input  logic       pop,
  output rec_t       head,
  output logic [1:0] count
);

  rec_t       mem [3];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd3) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap 0,1,2; storage is cleared on reset so head reads zero when idle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_rec;
        wr_ptr      <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fb_scan_reader.sv
// Raster read-back: walks every framebuffer address once per START and streams (data, x, y) out.
// Latency: START edge -> RdEn next cycle -> pixel valid two cycles later; 1 pixel/cycle with OutReady high.
// Backpressure: reads are issued only while buffered + in-flight pixels <= 2, so the 3-entry FIFO never overflows.
module fb_scan_reader import fb_pkg::*; #(
  parameter int X_RESOL = 16,
  parameter int X_ROWS  = 16,
  parameter int DATA_W  = FB_DATA_W,
  parameter int ADDR_W  = FB_ADDR_W
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               START,
  output logic               BUSY,
  output logic               DONE,
  output logic [ADDR_W-1:0]  RdAddr,
  output logic               RdEn,
  input  logic [DATA_W-1:0]  RdData,
  output logic [DATA_W-1:0]  OutData,
  output logic [COORD_W-1:0] OutX,
  output logic [COORD_W-1:0] OutY,
  output logic               OutFirst,
  output logic               OutLast,
  output logic               OutValid,
  input  logic               OutReady
);

  localparam int TOTAL = X_RESOL * X_ROWS;
  localparam int XW    = cnt_w(X_ROWS);
  localparam int YW    = cnt_w(X_RESOL);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [YW-1:0]     Y_MAX     = YW'(X_RESOL - 1);

  if (TOTAL > (1 << ADDR_W)) begin : g_size_check
    $error("fb_scan_reader: X_RESOL*X_ROWS does not fit in ADDR_W address bits");
  end

  // Record stored per buffered pixel, at this instance's data width.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               first;
    logic               last;
  } rec_t;

  scan_state_t       state;
  logic [ADDR_W-1:0] addr;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic              inflight;
  pix_meta_t         side_q;

  logic [1:0]        fifo_count;
  rec_t              fifo_head;
  rec_t              push_rec;
  logic              fifo_pop;
  logic [2:0]        occ;
  logic              issue;
  logic              drain_done;

  // Occupancy uses only registered terms, keeping OutReady off the RdEn path.
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight};
  assign issue    = (state == ST_SCAN) && (occ <= 3'd2);
  assign fifo_pop = OutValid && OutReady;

  // Frame is finished once nothing will remain buffered or in flight after this edge.
  assign drain_done = (state == ST_DRAIN) && ((occ - {2'b00, fifo_pop}) == 3'd0);

  assign RdEn   = issue;
  assign RdAddr = addr;

  assign push_rec = '{data:  RdData,
                      x:     side_q.x,
                      y:     side_q.y,
                      first: side_q.first,
                      last:  side_q.last};

  assign OutValid = (fifo_count != 2'd0);
  assign OutData  = fifo_head.data;
  assign OutX     = fifo_head.x;
  assign OutY     = fifo_head.y;
  assign OutFirst = fifo_head.first;
  assign OutLast  = fifo_head.last;

  // Scan FSM with raster counters; x/y follow addr so no divider is needed.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= ST_IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      addr  <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A START coinciding with the DONE pulse does not begin a new frame.
          if (START && !DONE) begin
            addr  <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
            BUSY  <= 1'b1;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (issue) begin
            if (addr == LAST_ADDR) begin
              // Park counters at zero instead of stepping past the frame.
              addr  <= '0;
              x_cnt <= '0;
              y_cnt <= '0;
              state <= ST_DRAIN;
            end else begin
              addr <= addr + ADDR_W'(1);
              if (y_cnt == Y_MAX) begin
                y_cnt <= '0;
                x_cnt <= x_cnt + XW'(1);
              end else begin
                y_cnt <= y_cnt + YW'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // One-stage side pipeline: coordinates wait one cycle to meet their read data.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      inflight <= 1'b0;
      side_q   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        side_q <= '{x:     COORD_W'(x_cnt),
                    y:     COORD_W'(y_cnt),
                    first: (addr == '0),
                    last:  (addr == LAST_ADDR)};
      end
    end
  end

  fb_fifo #(
    .rec_t (rec_t)
  ) u_fifo (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .push     (inflight),
    .push_rec (push_rec),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

endmodule
